fpnew_divsqrt_out_buffer: RTL and testbench
===========================================

# fpnew_divsqrt_out_buffer

Result buffer placed directly downstream of the multi-cycle divide/square-root unit, between its output handshake and the FPU output arbiter. It absorbs divsqrt results into a small in-order FIFO so the iterative unit can retire and accept new work while downstream is stalled. It optionally accumulates sticky IEEE exception flags of retired results. Flush discards all buffered entries.

## Interface
- `WIDTH`, default 64: result width; matches the FPU's maximum enabled format width.
- `Depth`, default 4: number of entries; must be ≥1; non-power-of-two values allowed.
- `TagType`, default `logic`: per-operation tag type, passed through unchanged.
- `AuxType`, default `logic`: per-operation aux type, passed through unchanged.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `result_i`, in, WIDTH: result from the divsqrt unit.
- `status_i`, in, `fpnew_pkg::status_t` (5 bits): exception flags NV/DZ/OF/UF/NX.
- `extension_bit_i`, in, 1: NaN-box extension bit.
- `tag_i`, in, TagType: tag.
- `aux_i`, in, AuxType: aux.
- `in_valid_i`, in, 1: upstream result valid.
- `in_ready_o`, out, 1: buffer can accept a result.
- `flush_i`, in, 1: synchronous discard of all contents.
- `result_o`, out, WIDTH: head entry result.
- `status_o`, out, status_t: head entry status.
- `extension_bit_o`, out, 1: head entry extension bit.
- `tag_o`, out, TagType: head entry tag.
- `aux_o`, out, AuxType: head entry aux.
- `out_valid_o`, out, 1: head entry valid.
- `out_ready_i`, in, 1: downstream accepts.
- `usage_o`, out, $clog2(Depth+1): current number of entries.
- `busy_o`, out, 1: high when usage_o ≠ 0.
- `flags_clear_i`, in, 1: clear sticky flags. Present only with the macro defined.
- `flags_o`, out, status_t: sticky flags. Present only with the macro defined.

## Operation
- Push when `in_valid_i & in_ready_o & ~flush_i`. Pop when `out_valid_o & out_ready_i & ~flush_i`.
- `in_ready_o = (usage != Depth)`.
  - Registered state only; no combinational path from `out_ready_i`.
  - A push into a full buffer is never accepted, even if a pop occurs in the same cycle.
- `out_valid_o = (usage != 0)`. Head fields are driven from storage at the read pointer.
- Read and write pointers increment on pop and push respectively. Each wraps from Depth-1 to 0 by explicit compare.
- Simultaneous push and pop with a non-empty buffer: usage unchanged, both pointers advance.
- Push into an empty buffer: `out_valid_o` rises the next cycle. There is no fall-through.
- `flush_i` has priority over push and pop in the same cycle. Pointers and usage clear to 0 the next cycle. Data from that cycle is dropped.
- Ordering is strictly FIFO. Tag, aux and extension bit travel with their result.

## Timing
- Reset values:
  - `usage_o` = 0, `out_valid_o` = 0, `busy_o` = 0, `in_ready_o` = 1.
  - All storage and head outputs = 0.
  - `flags_o` = 0.
- Latency from push to head visibility is 1 cycle when empty. Otherwise it equals the number of entries ahead of it.
- Throughput is 1 push and 1 pop per cycle.
- Reset asserted mid-operation clears everything asynchronously. No entries survive.

## Configuration
- Macro `FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN`.
- Defined:
  - `flags_o` and `flags_clear_i` exist.
  - `flags_q <= (flags_clear_i ? 0 : flags_q) | (pop ? status_o : 0)`.
  - Clear and pop in the same cycle yield exactly the popped status.
  - Flush does not clear the flags. Discarded entries never contribute.
- Not defined: both ports are absent and no flag register is built.

## Structure
- Use `fpnew_pkg::status_t` from the shared package.
- Add constant `fpnew_pkg::DIVSQRT_OUTBUF_DEPTH` = 4 for instantiating parents.
- No new typedefs. The entry struct {result, status, ext, tag, aux} is local, because it depends on TagType/AuxType.
- One natural sub-module: `fpnew_fflags_accum`, the sticky flag register with clear and accumulate, instantiated under the macro.

## Test plan
- Reset, then push results 0x3FF0000000000000 and 0x4000000000000000 with tags 1 and 2, `out_ready_i` = 1 → head shows tag 1 one cycle after its push, then tag 2. `usage_o` returns to 0.
- `out_ready_i` = 0, push 4 entries (Depth=4) → `in_ready_o` = 0 after the 4th. A 5th push with a simultaneous pop is rejected and usage becomes 3.
- Depth=3, 10 back-to-back pushes and pops with tags 0..9 → exact in-order tags out across pointer wrap. Usage stays 1.
- Buffer holding 3 entries, `flush_i` for 1 cycle with a concurrent push → next cycle usage 0, `out_valid_o` 0, `busy_o` 0. The pushed entry never appears.
- Macro defined: pop statuses 5'b00001 then 5'b10000 → `flags_o` = 5'b10001. Clear with a concurrent pop of 5'b00100 → 5'b00100.
- Reset asserted while 2 entries are held and `flags_o` ≠ 0 → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU package: IEEE exception status type and buffer sizing constant
// used by instantiating parents of the divsqrt output buffer.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned DIVSQRT_OUTBUF_DEPTH = 32'd4;

endpackage

// File: rtl/fpnew_fflags_accum.sv
// Sticky IEEE exception flag register: ORs in the status of each retired
// result; a clear in the same cycle as an accumulate keeps only the new status.
module fpnew_fflags_accum
    import fpnew_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    clear_i,
    input  logic    acc_en_i,
    input  status_t status_i,
    output status_t flags_o
);

    status_t flags_r;
    status_t flags_next_s;

    // Next-state: optionally cleared history merged with the accepted status
    always_comb begin
        flags_next_s = flags_r;
        if (clear_i) begin
            flags_next_s = status_t'(5'b00000);
        end else begin
            flags_next_s = flags_r;
        end
        if (acc_en_i) begin
            flags_next_s = status_t'(flags_next_s | status_i);
        end else begin
            flags_next_s = flags_next_s;
        end
    end

    // Flag state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_r <= status_t'(5'b00000);
        end else begin
            flags_r <= flags_next_s;
        end
    end

    assign flags_o = flags_r;

endmodule

// File: rtl/fpnew_divsqrt_out_buffer.sv
// In-order result FIFO between the divsqrt unit and the FPU output arbiter.
// Define FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN to add the sticky flag accumulator.
module fpnew_divsqrt_out_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           result_i,
    input  status_t                    status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    input  AuxType                     aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output AuxType                     aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
    input  logic                       flags_clear_i,
    output status_t                    flags_o,
`endif
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
    localparam int unsigned CntW = $clog2(Depth+1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic             ext;
        TagType           tag;
        AuxType           aux;
    } entry_t;

    entry_t            mem_r [Depth];
    entry_t            entry_in_s;
    entry_t            head_s;
    logic [PtrW-1:0]   wr_ptr_r, wr_ptr_next_s;
    logic [PtrW-1:0]   rd_ptr_r, rd_ptr_next_s;
    logic [CntW-1:0]   usage_r, usage_next_s;
    logic              push_s;
    logic              pop_s;

    // Ready/valid depend only on stored occupancy, so a full buffer rejects
    // a push even when the head is popped in the same cycle.
    assign in_ready_o  = (usage_r != CntW'(Depth));
    assign out_valid_o = (usage_r != CntW'(0));
    assign busy_o      = (usage_r != CntW'(0));
    assign usage_o     = usage_r;

    assign push_s = in_valid_i & in_ready_o & ~flush_i;
    assign pop_s  = out_valid_o & out_ready_i & ~flush_i;

    assign entry_in_s = '{result: result_i, status: status_i, ext: extension_bit_i,
                          tag: tag_i, aux: aux_i};

    assign head_s          = mem_r[rd_ptr_r];
    assign result_o        = head_s.result;
    assign status_o        = head_s.status;
    assign extension_bit_o = head_s.ext;
    assign tag_o           = head_s.tag;
    assign aux_o           = head_s.aux;

    // Pointer and occupancy next-state; flush overrides push and pop
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        usage_next_s  = usage_r;
        if (flush_i) begin
            wr_ptr_next_s = PtrW'(0);
            rd_ptr_next_s = PtrW'(0);
            usage_next_s  = CntW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_next_s = (wr_ptr_r == PtrW'(Depth-1)) ? PtrW'(0) : wr_ptr_r + PtrW'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = (rd_ptr_r == PtrW'(Depth-1)) ? PtrW'(0) : rd_ptr_r + PtrW'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   usage_next_s = usage_r + CntW'(1);
                2'b01:   usage_next_s = usage_r - CntW'(1);
                default: usage_next_s = usage_r;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= PtrW'(0);
            rd_ptr_r <= PtrW'(0);
            usage_r  <= CntW'(0);
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            usage_r  <= usage_next_s;
        end
    end

    // Entry storage, cleared on reset so the head reads zero while empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_in_s;
        end
    end

`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
    fpnew_fflags_accum i_fflags_accum (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (flags_clear_i),
        .acc_en_i (pop_s),
        .status_i (status_o),
        .flags_o  (flags_o)
    );
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_out_buffer.sv
// Directed self-checking bench for fpnew_divsqrt_out_buffer (Depth 4 and Depth 3).
module tb_fpnew_divsqrt_out_buffer;
    import fpnew_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic [63:0] result_i;
    status_t     status_i;
    logic        ext_i;
    logic [3:0]  tag_i;
    logic        aux_i;
    logic        flush_i;
    logic        flags_clear_i;

    logic        in_valid4, out_ready4, in_ready4, out_valid4, ext4, aux4, busy4;
    logic [63:0] result4;
    status_t     status4;
    logic [3:0]  tag4;
    logic [2:0]  usage4;
    status_t     flags4;

    logic        in_valid3, out_ready3, in_ready3, out_valid3, ext3, aux3, busy3;
    logic [63:0] result3;
    status_t     status3;
    logic [3:0]  tag3;
    logic [1:0]  usage3;
    status_t     flags3;

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpnew_divsqrt_out_buffer #(.WIDTH(64), .Depth(4), .TagType(logic [3:0]), .AuxType(logic)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .result_i(result_i), .status_i(status_i),
        .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid4),
        .in_ready_o(in_ready4), .flush_i(flush_i), .result_o(result4), .status_o(status4),
        .extension_bit_o(ext4), .tag_o(tag4), .aux_o(aux4), .out_valid_o(out_valid4),
        .out_ready_i(out_ready4),
`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
        .flags_clear_i(flags_clear_i), .flags_o(flags4),
`endif
        .usage_o(usage4), .busy_o(busy4)
    );

    fpnew_divsqrt_out_buffer #(.WIDTH(64), .Depth(3), .TagType(logic [3:0]), .AuxType(logic)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .result_i(result_i), .status_i(status_i),
        .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid3),
        .in_ready_o(in_ready3), .flush_i(flush_i), .result_o(result3), .status_o(status3),
        .extension_bit_o(ext3), .tag_o(tag3), .aux_o(aux3), .out_valid_o(out_valid3),
        .out_ready_i(out_ready3),
`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
        .flags_clear_i(flags_clear_i), .flags_o(flags3),
`endif
        .usage_o(usage3), .busy_o(busy3)
    );

`ifndef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
    assign flags4 = status_t'(5'b00000);
    assign flags3 = status_t'(5'b00000);
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; result_i = 64'd0; status_i = status_t'(5'b00000); ext_i = 1'b0;
        tag_i = 4'd0; aux_i = 1'b0; flush_i = 1'b0; flags_clear_i = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();
        checks++; if (usage4 !== 3'd0) begin fails++; $display("FAIL reset_usage got %0d want 0", usage4); end
        checks++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid4); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready4); end
        checks++; if (result4 !== 64'd0 || tag4 !== 4'd0) begin fails++; $display("FAIL reset_head got %h/%0d want 0/0", result4, tag4); end
        checks++; if (usage3 !== 2'd0 || in_ready3 !== 1'b1) begin fails++; $display("FAIL reset_dut3 got usage %0d ready %b want 0/1", usage3, in_ready3); end
    endtask

    task automatic test_basic_order();
        out_ready4 = 1'b1; in_valid4 = 1'b1; result_i = 64'h3FF0000000000000; tag_i = 4'd1; ext_i = 1'b1; aux_i = 1'b1;
        step();
        checks++; if (out_valid4 !== 1'b1 || tag4 !== 4'd1) begin fails++; $display("FAIL basic_head1 got v=%b tag=%0d want v=1 tag=1", out_valid4, tag4); end
        checks++; if (result4 !== 64'h3FF0000000000000 || ext4 !== 1'b1 || aux4 !== 1'b1) begin fails++; $display("FAIL basic_data1 got %h ext %b aux %b want 3ff0000000000000/1/1", result4, ext4, aux4); end
        result_i = 64'h4000000000000000; tag_i = 4'd2; ext_i = 1'b0; aux_i = 1'b0;
        step();
        checks++; if (tag4 !== 4'd2 || result4 !== 64'h4000000000000000 || usage4 !== 3'd1) begin fails++; $display("FAIL basic_head2 got tag %0d res %h usage %0d want 2/4000000000000000/1", tag4, result4, usage4); end
        in_valid4 = 1'b0;
        step();
        checks++; if (usage4 !== 3'd0 || out_valid4 !== 1'b0) begin fails++; $display("FAIL basic_drain got usage %0d v %b want 0/0", usage4, out_valid4); end
    endtask

    task automatic test_full();
        out_ready4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tag_i = 4'(i + 3); result_i = 64'(i + 100);
            step();
        end
        checks++; if (in_ready4 !== 1'b0 || usage4 !== 3'd4) begin fails++; $display("FAIL full_ready got ready %b usage %0d want 0/4", in_ready4, usage4); end
        tag_i = 4'd7; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        checks++; if (usage4 !== 3'd3 || tag4 !== 4'd4) begin fails++; $display("FAIL full_reject got usage %0d tag %0d want 3/4", usage4, tag4); end
        step();
        checks++; if (tag4 !== 4'd5 || result4 !== 64'd102) begin fails++; $display("FAIL full_order5 got %0d/%0d want 5/102", tag4, result4); end
        step();
        checks++; if (tag4 !== 4'd6) begin fails++; $display("FAIL full_order6 got %0d want 6", tag4); end
        step();
        checks++; if (usage4 !== 3'd0 || out_valid4 !== 1'b0) begin fails++; $display("FAIL full_drain got usage %0d v %b want 0/0", usage4, out_valid4); end
        out_ready4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready3 = 1'b1; in_valid3 = 1'b1; tag_i = 4'd0;
        step();
        checks++; if (tag3 !== 4'd0 || usage3 !== 2'd1) begin fails++; $display("FAIL b2b_tag0 got %0d usage %0d want 0/1", tag3, usage3); end
        for (int i = 1; i < 10; i++) begin
            tag_i = 4'(i);
            step();
            checks++; if (tag3 !== 4'(i) || usage3 !== 2'd1) begin fails++; $display("FAIL b2b_tag%0d got %0d usage %0d want %0d/1", i, tag3, usage3, i); end
        end
        in_valid3 = 1'b0;
        step();
        checks++; if (usage3 !== 2'd0) begin fails++; $display("FAIL b2b_drain got %0d want 0", usage3); end
        out_ready3 = 1'b0;
    endtask

    task automatic test_flush();
        out_ready4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tag_i = 4'(i + 8); status_i = status_t'(5'b11111);
            step();
        end
        checks++; if (usage4 !== 3'd3) begin fails++; $display("FAIL flush_fill got %0d want 3", usage4); end
        flush_i = 1'b1; tag_i = 4'd11; out_ready4 = 1'b1;
        step();
        flush_i = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; status_i = status_t'(5'b00000);
        checks++; if (usage4 !== 3'd0 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin fails++; $display("FAIL flush_clear got usage %0d v %b busy %b ready %b want 0/0/0/1", usage4, out_valid4, busy4, in_ready4); end
        in_valid4 = 1'b1; tag_i = 4'd12;
        step();
        in_valid4 = 1'b0;
        checks++; if (tag4 !== 4'd12 || usage4 !== 3'd1) begin fails++; $display("FAIL flush_after got tag %0d usage %0d want 12/1", tag4, usage4); end
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        checks++; if (usage4 !== 3'd0) begin fails++; $display("FAIL flush_drain got %0d want 0", usage4); end
`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
        checks++; if (flags4 !== status_t'(5'b00000)) begin fails++; $display("FAIL flush_flags got %b want 00000", flags4); end
`endif
    endtask

`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
    task automatic test_sticky_flags();
        out_ready4 = 1'b0; in_valid4 = 1'b1;
        status_i = status_t'(5'b00001); step();
        status_i = status_t'(5'b10000); step();
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        step();
        checks++; if (flags4 !== status_t'(5'b00001)) begin fails++; $display("FAIL flags_first got %b want 00001", flags4); end
        step();
        checks++; if (flags4 !== status_t'(5'b10001)) begin fails++; $display("FAIL flags_accum got %b want 10001", flags4); end
        out_ready4 = 1'b0; in_valid4 = 1'b1; status_i = status_t'(5'b00100);
        step();
        in_valid4 = 1'b0; out_ready4 = 1'b1; flags_clear_i = 1'b1;
        step();
        flags_clear_i = 1'b0; out_ready4 = 1'b0; status_i = status_t'(5'b00000);
        checks++; if (flags4 !== status_t'(5'b00100)) begin fails++; $display("FAIL flags_clear_pop got %b want 00100", flags4); end
    endtask
`endif

    task automatic test_async_reset();
        out_ready4 = 1'b0; in_valid4 = 1'b1; status_i = status_t'(5'b01000);
        tag_i = 4'd1; result_i = 64'hDEADBEEF00000001; step();
        tag_i = 4'd2; step();
        in_valid4 = 1'b0;
        checks++; if (usage4 !== 3'd2 || tag4 !== 4'd1) begin fails++; $display("FAIL areset_setup got usage %0d tag %0d want 2/1", usage4, tag4); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (usage4 !== 3'd0 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin fails++; $display("FAIL areset_ctrl got usage %0d v %b busy %b ready %b want 0/0/0/1", usage4, out_valid4, busy4, in_ready4); end
        checks++; if (result4 !== 64'd0 || tag4 !== 4'd0 || status4 !== status_t'(5'b00000) || flags4 !== status_t'(5'b00000)) begin fails++; $display("FAIL areset_data got %h tag %0d st %b flags %b want zeros", result4, tag4, status4, flags4); end
        step();
        rst_ni = 1'b1;
        step();
        checks++; if (usage4 !== 3'd0 || out_valid4 !== 1'b0) begin fails++; $display("FAIL areset_after got usage %0d v %b want 0/0", usage4, out_valid4); end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full();
        test_back_to_back();
        test_flush();
`ifdef FPNEW_DIVSQRT_OUTBUF_STICKY_FLAGS_EN
        test_sticky_flags();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
